// File: rtl/packet_link_pkg.sv
// Shared definitions for the serial packet link: FSM states, CRC-8 constants
// and the serial CRC step used by both receiver hardware and its bench model.
package packet_link_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MODE = 3'd1,
    DATA = 3'd2,
    CRC  = 3'd3,
    STOP = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0] CRC_POLY  = 8'h07;
  localparam logic [7:0] CRC_INIT  = 8'h00;
  localparam int         CRC_LEN   = 8;
  localparam logic       START_BIT = 1'b0;
  localparam logic       STOP_BIT  = 1'b1;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       bit_in,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/packet_deserializer_rx_if.sv
// Serial line plus received-word/status bundle of the packet receiver.
// err_count exists only when PACKET_RX_ERR_CNT_EN is defined.
interface packet_deserializer_rx_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic             packet;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             crc_err;
  logic             frame_err;
  logic             busy;
`ifdef PACKET_RX_ERR_CNT_EN
  logic [7:0]       err_count;
`endif

  // Link side: drives the line and consumes the received word.
  modport master (
    output enable, packet,
`ifdef PACKET_RX_ERR_CNT_EN
    input  err_count,
`endif
    input  rx_data, rx_valid, crc_err, frame_err, busy
  );

  // Receiver side.
  modport slave (
    input  enable, packet,
`ifdef PACKET_RX_ERR_CNT_EN
    output err_count,
`endif
    output rx_data, rx_valid, crc_err, frame_err, busy
  );

endinterface

// File: rtl/packet_deserializer_rx_crc8.sv
// Serial CRC-8 LFSR: clear loads INIT, each enabled cycle folds in one bit.
module crc8_serial
  import packet_link_pkg::*;
#(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= INIT;
    end else if (bit_en) begin
      crc <= crc8_step(crc, bit_in, POLY);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/packet_deserializer_rx.sv
// Packet link receiver: start-bit detect, in-band mode bit, LSB-first payload,
// optional MSB-first CRC-8 trailer, stop bit. PACKET_RX_ERR_CNT_EN adds err_count.
module packet_deserializer_rx
  import packet_link_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [7:0] CRC_POLY = packet_link_pkg::CRC_POLY,
  parameter logic [7:0] CRC_INIT = packet_link_pkg::CRC_INIT
) (
  input  logic                     clk,
  input  logic                     resetn,
  packet_deserializer_rx_if.slave  link
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = IDX_W + 1;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [7:0]       crc_rx;
  logic [7:0]       crc_calc;
  logic             mode_r;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             crc_err;
  logic             frame_err;
  logic             busy;
  logic             start_seen;
  logic             crc_clear;
  logic             crc_en;

  // A start bit is accepted from IDLE or directly in DONE (back-to-back frames).
  assign start_seen = link.enable && (link.packet == START_BIT) &&
                      ((state == IDLE) || (state == DONE));
  assign crc_clear  = start_seen;
  assign crc_en     = link.enable && (state == DATA);

  crc8_serial #(
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_crc (
    .clk    (clk),
    .resetn (resetn),
    .clear  (crc_clear),
    .bit_en (crc_en),
    .bit_in (link.packet),
    .crc    (crc_calc)
  );

  // Receive FSM; result and flags are registered on the stop-bit edge so they
  // are visible during DONE, one cycle after the stop bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bit_cnt   <= {CNT_W{1'b0}};
      shreg     <= {WIDTH{1'b0}};
      crc_rx    <= 8'h00;
      mode_r    <= 1'b0;
      rx_data   <= {WIDTH{1'b0}};
      rx_valid  <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      if (!link.enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (link.packet == START_BIT) begin
              state   <= MODE;
              busy    <= 1'b1;
              bit_cnt <= {CNT_W{1'b0}};
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          MODE: begin
            mode_r <= link.packet;
            state  <= DATA;
          end
          DATA: begin
            shreg[bit_cnt[IDX_W-1:0]] <= link.packet;
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              bit_cnt <= {CNT_W{1'b0}};
              state   <= mode_r ? CRC : STOP;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          CRC: begin
            crc_rx <= {crc_rx[6:0], link.packet};
            if (bit_cnt == CNT_W'(CRC_LEN - 1)) begin
              bit_cnt <= {CNT_W{1'b0}};
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          STOP: begin
            rx_valid  <= 1'b1;
            rx_data   <= shreg;
            crc_err   <= mode_r && (crc_rx != crc_calc);
            frame_err <= (link.packet != STOP_BIT);
            state     <= DONE;
          end
          DONE: begin
            if (link.packet == START_BIT) begin
              state   <= MODE;
              busy    <= 1'b1;
              bit_cnt <= {CNT_W{1'b0}};
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign link.rx_data   = rx_data;
  assign link.rx_valid  = rx_valid;
  assign link.crc_err   = crc_err;
  assign link.frame_err = frame_err;
  assign link.busy      = busy;

`ifdef PACKET_RX_ERR_CNT_EN
  logic [7:0] err_count;

  // One count per errored frame, saturating; any disabled cycle clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_count <= 8'h00;
    end else if (!link.enable) begin
      err_count <= 8'h00;
    end else if ((state == DONE) && (crc_err || frame_err) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'h01;
    end else begin
      err_count <= err_count;
    end
  end

  assign link.err_count = err_count;
`endif

endmodule

// File: tb/tb_packet_deserializer_rx.sv
// Scoreboard bench for packet_deserializer_rx: frames push expected results,
// a negedge monitor pops and compares on each rx_valid.
module tb_packet_deserializer_rx;
  import packet_link_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] data;
    logic        ce;
    logic        fe;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] cyc = 32'd0;
  int          tests = 0;
  int          fails = 0;
  exp_t        q[$];

  packet_deserializer_rx_if #(.WIDTH(WIDTH)) link();

  packet_deserializer_rx #(
    .WIDTH    (WIDTH),
    .CRC_POLY (8'h07),
    .CRC_INIT (8'h00)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .link   (link)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every valid must match the head of the scoreboard, flags idle otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1) begin
      if (link.rx_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rx_data", link.rx_data, e.data);
          chk("crc_err", {31'd0, link.crc_err}, {31'd0, e.ce});
          chk("frame_err", {31'd0, link.frame_err}, {31'd0, e.fe});
          chk("valid_latency", cyc, e.cyc);
        end
      end else begin
        chk("flags_idle", {30'd0, link.crc_err, link.frame_err}, 32'd0);
      end
    end
  end

  task automatic drive(input logic b);
    @(negedge clk);
    link.packet = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1);
  endtask

  task automatic send_frame(input logic mode, input logic [31:0] d, input logic [7:0] cf,
                            input logic stop, input logic ce, input logic fe);
    exp_t e;
    @(negedge clk);
    link.packet = START_BIT;
    e.data = d;
    e.ce   = ce;
    e.fe   = fe;
    e.cyc  = cyc + (mode ? 32'd43 : 32'd35);
    q.push_back(e);
    drive(mode);
    for (int i = 0; i < WIDTH; i++) drive(d[i]);
    if (mode) begin
      for (int i = 7; i >= 0; i--) drive(cf[i]);
    end
    drive(stop);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  crc_a;
    logic [31:0] pat;
    resetn      = 1'b0;
    link.enable = 1'b0;
    link.packet = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", link.rx_data, 32'd0);
    chk("reset_rx_valid", {31'd0, link.rx_valid}, 32'd0);
    chk("reset_flags", {30'd0, link.crc_err, link.frame_err}, 32'd0);
    chk("reset_busy", {31'd0, link.busy}, 32'd0);
`ifdef PACKET_RX_ERR_CNT_EN
    chk("reset_err_count", {24'd0, link.err_count}, 32'd0);
`endif
    resetn      = 1'b1;
    link.enable = 1'b1;
    idle(3);

    // Good CRC frame, then bad CRC frame, then mode-0 frame with bad stop bit.
    send_frame(1'b1, 32'h0000_0001, 8'h31, 1'b1, 1'b0, 1'b0);
    idle(3);
    send_frame(1'b1, 32'h0000_0000, 8'h01, 1'b1, 1'b1, 1'b0);
    idle(3);
`ifdef PACKET_RX_ERR_CNT_EN
    chk("err_count_after_crc_err", {24'd0, link.err_count}, 32'd1);
`endif
    send_frame(1'b0, 32'hDEAD_BEEF, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(3);
`ifdef PACKET_RX_ERR_CNT_EN
    chk("err_count_after_frame_err", {24'd0, link.err_count}, 32'd2);
`endif

    // Back-to-back frames: second start bit lands in the DONE cycle.
    crc_a = 8'h00;
    pat   = 32'hA5A5_A5A5;
    for (int i = 0; i < WIDTH; i++) crc_a = crc8_step(crc_a, pat[i], 8'h07);
    send_frame(1'b1, 32'hA5A5_A5A5, crc_a, 1'b1, 1'b0, 1'b0);
    send_frame(1'b1, 32'h0000_0001, 8'h31, 1'b1, 1'b0, 1'b0);
    idle(3);

    // enable dropped at payload bit 10.
    pat = 32'h1234_5678;
    drive(START_BIT);
    drive(1'b1);
    for (int i = 0; i < 10; i++) drive(pat[i]);
    chk("busy_mid_frame", {31'd0, link.busy}, 32'd1);
    @(negedge clk);
    link.packet = pat[10];
    link.enable = 1'b0;
    @(negedge clk);
    chk("busy_after_disable", {31'd0, link.busy}, 32'd0);
    chk("rx_data_held", link.rx_data, 32'h0000_0001);
    link.enable = 1'b1;
    link.packet = 1'b1;
`ifdef PACKET_RX_ERR_CNT_EN
    chk("err_count_cleared_by_disable", {24'd0, link.err_count}, 32'd0);
`endif
    idle(3);

    // resetn pulsed at payload bit 5 of the next frame.
    drive(START_BIT);
    drive(1'b1);
    for (int i = 0; i < 5; i++) drive(pat[i]);
    chk("busy_before_reset", {31'd0, link.busy}, 32'd1);
    @(negedge clk);
    link.packet = pat[5];
    resetn      = 1'b0;
    #1;
    chk("async_reset_rx_data", link.rx_data, 32'd0);
    chk("async_reset_busy", {31'd0, link.busy}, 32'd0);
    chk("async_reset_valid", {31'd0, link.rx_valid}, 32'd0);
    @(negedge clk);
    resetn      = 1'b1;
    link.packet = 1'b1;
    idle(50);
    chk("busy_after_reset", {31'd0, link.busy}, 32'd0);
    chk("rx_data_after_reset", link.rx_data, 32'd0);

`ifdef PACKET_RX_ERR_CNT_EN
    // Both errors in one frame count once; then saturate and clear.
    send_frame(1'b1, 32'h0000_0000, 8'h01, 1'b0, 1'b1, 1'b1);
    idle(2);
    chk("err_count_single_inc", {24'd0, link.err_count}, 32'd1);
    for (int n = 0; n < 299; n++) begin
      send_frame(1'b1, 32'h0000_0000, 8'h01, 1'b1, 1'b1, 1'b0);
      idle(1);
    end
    idle(2);
    chk("err_count_saturated", {24'd0, link.err_count}, 32'd255);
    @(negedge clk);
    link.enable = 1'b0;
    @(negedge clk);
    link.enable = 1'b1;
    chk("err_count_cleared", {24'd0, link.err_count}, 32'd0);
`endif

    idle(5);
    chk("pending_frames", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
